// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache.
// Hits return data in the same cycle. A miss waits in FETCH until memory answers,
// fills the frame, and then goes back to IDLE.
module icache #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned TAG_W = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            r_state;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_hit;
  logic              w_fill;

  // Address split for the lookup and for the pending fill.
  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag = r_miss_addr[31:IDX_W+2];

  // A hit is only possible in IDLE. The fetch stage needs 0-cycle latency, so it
  // is decoded straight from imemaddr.
  assign w_hit  = (r_state == IDLE) && imemREN && r_valid[w_idx] &&
                  (r_tag[w_idx] == w_tag);
  assign w_fill = (r_state == FETCH) && !iwait;

  assign ihit       = w_hit;
  assign imemload   = w_hit ? r_data[w_idx] : 32'd0;
  assign iREN       = (r_state == FETCH);
  assign iaddr      = r_miss_addr;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Control FSM, valid bits, miss address latch and the performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_addr  <= 32'd0;
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imemREN) begin
            if (w_hit) begin
              r_hit_count <= r_hit_count + 32'd1;
            end else begin
              r_miss_addr  <= {imemaddr[31:2], 2'b00};
              r_miss_count <= r_miss_count + 32'd1;
              r_state      <= FETCH;
            end
          end
        end
        FETCH: begin
          // Once started, the memory transaction always runs to completion,
          // even if the fetch address has been redirected in the meantime.
          if (!iwait) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_state             <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Frame tag/data storage. It has no reset because valid gates every read.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic,
// checked every cycle against a word-address-level model of the cache.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp  = 0;
  int n_fail = 0;

  icache #(.SETS(16), .TAG_W(26)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each frame remembers which word address it holds.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  bit          m_pend;
  logic [31:0] m_paddr;
  logic [31:0] m_hc;
  logic [31:0] m_mc;

  function automatic bit m_hit(input logic ren, input logic [31:0] a);
    return !m_pend && ren && m_valid[a[5:2]] && (m_word[a[5:2]] == a[31:2]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_pend  = 1'b0;
    m_paddr = 32'd0;
    m_hc    = 32'd0;
    m_mc    = 32'd0;
  endtask

  // Compare at the falling edge, advance the model at the rising edge.
  initial begin
    bit h;
    m_reset();
    forever begin
      @(negedge CLK);
      if (!nRST) m_reset();
      h = m_hit(imemREN, imemaddr);
      chk("ihit", 32'(ihit), 32'(h));
      chk("imemload", imemload, h ? m_data[imemaddr[5:2]] : 32'd0);
      chk("iREN", 32'(iREN), 32'(m_pend));
      if (m_pend || !nRST) chk("iaddr", iaddr, m_paddr);
      chk("hit_count", hit_count, m_hc);
      chk("miss_count", miss_count, m_mc);
      @(posedge CLK);
      if (!nRST) begin
        m_reset();
      end else if (!m_pend) begin
        if (imemREN) begin
          if (m_hit(imemREN, imemaddr)) begin
            m_hc = m_hc + 32'd1;
          end else begin
            m_mc    = m_mc + 32'd1;
            m_pend  = 1'b1;
            m_paddr = {imemaddr[31:2], 2'b00};
          end
        end
      end else if (!iwait) begin
        m_valid[m_paddr[5:2]] = 1'b1;
        m_word[m_paddr[5:2]]  = m_paddr[31:2];
        m_data[m_paddr[5:2]]  = iload;
        m_pend = 1'b0;
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Take a miss on a, answered at once with d; return in IDLE with a still requested.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input string tag);
    imemREN = 1'b1; imemaddr = a; iwait = 1'b0; iload = d;
    #1 chk({tag, "_miss_ihit"}, 32'(ihit), 32'd0);
    cyc();
    #1 chk({tag, "_iaddr"}, iaddr, {a[31:2], 2'b00});
    cyc();
    #1 chk({tag, "_fill_ihit"}, 32'(ihit), 32'd1);
    chk({tag, "_fill_data"}, imemload, d);
  endtask

  initial begin
    logic [31:0] hc0, mc0;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;
    repeat (3) cyc();
    #1 chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hc", hit_count, 32'd0);
    chk("rst_mc", miss_count, 32'd0);
    cyc();
    nRST = 1'b1;

    // First fetch: miss, fill, then the same address hits.
    imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b0; iload = 32'h2001_0005;
    #1 chk("t1_ihit0", 32'(ihit), 32'd0);
    cyc();
    #1 chk("t1_iREN", 32'(iREN), 32'd1);
    chk("t1_iaddr", iaddr, 32'h0);
    chk("t1_ihit_fetch", 32'(ihit), 32'd0);
    cyc();
    #1 chk("t1_ihit", 32'(ihit), 32'd1);
    chk("t1_load", imemload, 32'h2001_0005);
    cyc();
    imemREN = 1'b0;
    #1 chk("t1_hc", hit_count, 32'd1);
    chk("t1_mc", miss_count, 32'd1);

    // Long memory wait: iREN stays high, and exactly one miss is counted.
    imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b1; iload = 32'hDEAD_0004;
    cyc();
    repeat (5) begin
      #1 chk("t2_iREN", 32'(iREN), 32'd1);
      chk("t2_ihit", 32'(ihit), 32'd0);
      cyc();
    end
    iwait = 1'b0;
    cyc();
    #1 chk("t2_ihit", 32'(ihit), 32'd1);
    chk("t2_load", imemload, 32'hDEAD_0004);
    chk("t2_mc", miss_count, 32'd2);

    // Conflict on index 2: each fill evicts the other address.
    do_miss(32'h08, 32'hAAAA_0008, "t3a");
    cyc();
    do_miss(32'h48, 32'hBBBB_0048, "t3b");
    cyc();
    do_miss(32'h08, 32'hCCCC_0008, "t3c");
    cyc();

    // Redirect while in FETCH: the fill for the old address still completes.
    imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1; iload = 32'h1111_0010;
    cyc();
    imemaddr = 32'h20;
    #1 chk("t4_iaddr", iaddr, 32'h10);
    cyc();
    iwait = 1'b0;
    cyc();
    #1 chk("t4_new_miss", 32'(ihit), 32'd0);
    iload = 32'h2222_0020;
    cyc();
    cyc();
    #1 chk("t4_20_hit", 32'(ihit), 32'd1);
    cyc();
    imemaddr = 32'h10;
    #1 chk("t4_10_hit", 32'(ihit), 32'd1);
    chk("t4_10_load", imemload, 32'h1111_0010);
    cyc();

    // Reset during FETCH: iREN drops at once and nothing is filled.
    imemREN = 1'b1; imemaddr = 32'h30; iwait = 1'b1; iload = 32'h3333_0030;
    cyc();
    #1 chk("t5_iREN_pre", 32'(iREN), 32'd1);
    nRST = 1'b0;
    #1 chk("t5_iREN_async", 32'(iREN), 32'd0);
    chk("t5_hc", hit_count, 32'd0);
    chk("t5_mc", miss_count, 32'd0);
    cyc();
    nRST = 1'b1; iwait = 1'b0;
    #1 chk("t5_remiss", 32'(ihit), 32'd0);
    cyc();
    cyc();
    #1 chk("t5_fill_hit", 32'(ihit), 32'd1);

    // No request: no hit and no counter change, even with a valid frame.
    imemREN = 1'b0;
    hc0 = 32'd0; mc0 = 32'd1;
    #1 chk("t6_ihit", 32'(ihit), 32'd0);
    chk("t6_load", imemload, 32'd0);
    cyc();
    cyc();
    #1 chk("t6_hc", hit_count, hc0);
    chk("t6_mc", miss_count, mc0);
    chk("t6_iREN", 32'(iREN), 32'd0);

    // Random traffic over a small address pool, so hits, conflicts and redirects all occur.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      imemREN  = ($urandom_range(0, 9) != 0);
      imemaddr = {28'($urandom_range(0, 2)), 4'($urandom_range(0, 15))} << 2;
      imemaddr[1:0] = 2'($urandom_range(0, 3));
      iwait    = ($urandom_range(0, 2) != 0);
      iload    = $urandom;
      if (i == 2000) nRST = 1'b0;
      if (i == 2002) nRST = 1'b1;
    end
    cyc();
    imemREN = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
